bcd_cmp_seq: RTL and testbench
==============================

BCD_CMP_SEQ -- requirements
Module: bcd_cmp_seq

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 The module SHALL have port start, input, 1 bit: request a compare; sampled only in IDLE.
REQ-004 The module SHALL have port A, input, 12 bits: operand A magnitude, 3 BCD digits, A[11:8] most significant.
REQ-005 The module SHALL have port sign_a, input, 1 bit: sign of A; 1 = negative.
REQ-006 The module SHALL have port B, input, 12 bits: operand B magnitude, same format as A.
REQ-007 The module SHALL have port sign_b, input, 1 bit: sign of B; 1 = negative.
REQ-008 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-010 The module SHALL have ports less, equal, greater, outputs, 1 bit each: signed relation of A to B.
REQ-011 The module SHALL have port invalid, output, 1 bit: set when any operand digit is greater than 9.

Function
REQ-012 The FSM SHALL have states IDLE, SIGN, DIG2, DIG1, DIG0 and DONE.
REQ-013 In IDLE with start=1, the module SHALL latch A, B, sign_a and sign_b, clear less/equal/greater/invalid, and go to SIGN.
REQ-014 start SHALL be ignored outside IDLE, and operand inputs SHALL be ignored after latching.
REQ-015 In SIGN, if any latched digit is greater than 9, the module SHALL set invalid=1, keep less/equal/greater=0, and go to DONE.
REQ-016 Zero SHALL be signless: a magnitude of 000 with either sign compares equal to 000 with either sign.
REQ-017 In SIGN with signs different and the magnitudes not both zero, the result SHALL be decided (positive operand greater), then go to DONE.
REQ-018 Otherwise SIGN SHALL go to DIG2; both-zero magnitudes SHALL take the digit path and resolve equal.
REQ-019 Each DIGn state SHALL compare one digit pair per cycle, most significant digit first.
- Digits unequal: decide the result and go to DONE.
- Digits equal: go to the next lower digit.
- DIG0 with digits equal: result is equal.
REQ-020 When both operands are negative and their magnitudes are nonzero, a digit-level less/greater decision SHALL be inverted.
REQ-021 done SHALL assert after this many rising edges from the sampling edge:
- 2 for a sign-decided or invalid result;
- 3, 4 or 5 for a decision in DIG2, DIG1 or DIG0 respectively.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 When a result is valid, exactly one of less, equal and greater SHALL be 1.
REQ-024 less, equal, greater and invalid SHALL hold their values after DONE until the next accepted start.
REQ-025 A start asserted in the DONE cycle SHALL be ignored; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-026 While rst=1, the state SHALL be IDLE and busy, done, less, equal, greater and invalid SHALL all be 0, regardless of clk.
REQ-027 Asserting rst mid-operation SHALL abort the compare immediately, with no done pulse and no partial result.
REQ-028 The first rising edge after rst deasserts SHALL be able to accept a start.

Verification
REQ-029 The bench SHALL check: +001 vs +007 -> less=1, equal=0, greater=0, done 5 edges after start.
REQ-030 The bench SHALL check: +500 vs +200 -> greater=1, done 3 edges after start.
REQ-031 The bench SHALL check: -125 vs -128 -> greater=1 (inverted), done 5 edges; and -300 vs +001 -> less=1, done 2 edges.
REQ-032 The bench SHALL check: -000 vs +000 -> equal=1, done 5 edges; and +888 vs +888 -> equal=1, done 5 edges.
REQ-033 The bench SHALL check: A=12'h1A3 -> invalid=1, less/equal/greater=0, done 2 edges after start.
REQ-034 The bench SHALL check: rst pulsed in DIG1 -> all outputs 0 at once, no done pulse; a new start 1 edge after rst release completes normally; start held high through busy is ignored.

Source files
------------

// File: rtl/bcd_cmp_seq_if.sv
// Bus bundle for bcd_cmp_seq: operand/request inputs, status/result outputs,
// and a debug view of the controller state.
//
// Handshake: the master raises start with A/B/sign_a/sign_b stable; the slave
// accepts only while busy=0 (IDLE), captures the operands on that rising edge
// and raises busy.  The result flags are valid while done=1 (one cycle) and
// stay stable until the next accepted start.  start seen while busy=1 is
// ignored.
interface bcd_cmp_seq_if;
  logic        start;
  logic [11:0] A;
  logic        sign_a;
  logic [11:0] B;
  logic        sign_b;
  logic        busy;
  logic        done;
  logic        less;
  logic        equal;
  logic        greater;
  logic        invalid;
  logic [2:0]  dbg_state;

  modport master (
    output start, A, sign_a, B, sign_b,
    input  busy, done, less, equal, greater, invalid, dbg_state
  );

  modport slave (
    input  start, A, sign_a, B, sign_b,
    output busy, done, less, equal, greater, invalid, dbg_state
  );
endinterface

// File: rtl/bcd_cmp_seq.sv
// Sequential signed 3-digit BCD comparator.  Signs (and digit validity) are
// resolved in one cycle; otherwise one BCD digit pair is compared per cycle,
// most significant first.  Zero is signless, and a digit-level decision is
// inverted when both operands are negative.
module bcd_cmp_seq (
  input  logic         clk,
  input  logic         rst,
  bcd_cmp_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SIGN = 3'd1;
  localparam logic [2:0] S_DIG2 = 3'd2;
  localparam logic [2:0] S_DIG1 = 3'd3;
  localparam logic [2:0] S_DIG0 = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]  state;
  logic [11:0] la;
  logic [11:0] lb;
  logic        lsa;
  logic        lsb;
  logic        less_r;
  logic        equal_r;
  logic        greater_r;
  logic        invalid_r;

  logic        any_bad;
  logic        a_zero;
  logic        b_zero;
  logic        invert;
  logic [3:0]  dig_a;
  logic [3:0]  dig_b;
  logic        dig_gt;

  // Operand classification on the latched values.
  always_comb begin
    any_bad = (la[11:8] > 4'd9) || (la[7:4] > 4'd9) || (la[3:0] > 4'd9) ||
              (lb[11:8] > 4'd9) || (lb[7:4] > 4'd9) || (lb[3:0] > 4'd9);
    a_zero  = (la == 12'h000);
    b_zero  = (lb == 12'h000);
    // Both negative: larger magnitude means smaller value.  When one of two
    // negatives is zero the inversion is still right (-0 > -n).
    invert  = lsa & lsb;
  end

  // Pick the digit pair that the current DIGn state examines.
  always_comb begin
    dig_a = la[11:8];
    dig_b = lb[11:8];
    case (state)
      S_DIG1: begin
        dig_a = la[7:4];
        dig_b = lb[7:4];
      end
      S_DIG0: begin
        dig_a = la[3:0];
        dig_b = lb[3:0];
      end
      default: begin
        dig_a = la[11:8];
        dig_b = lb[11:8];
      end
    endcase
    dig_gt = (dig_a > dig_b);
  end

  // Controller: operand capture, sign/validity resolution, digit walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      la        <= 12'h000;
      lb        <= 12'h000;
      lsa       <= 1'b0;
      lsb       <= 1'b0;
      less_r    <= 1'b0;
      equal_r   <= 1'b0;
      greater_r <= 1'b0;
      invalid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            la        <= bus.A;
            lb        <= bus.B;
            lsa       <= bus.sign_a;
            lsb       <= bus.sign_b;
            less_r    <= 1'b0;
            equal_r   <= 1'b0;
            greater_r <= 1'b0;
            invalid_r <= 1'b0;
            state     <= S_SIGN;
          end
        end
        S_SIGN: begin
          if (any_bad) begin
            invalid_r <= 1'b1;
            state     <= S_DONE;
          end else if ((lsa != lsb) && !(a_zero && b_zero)) begin
            // The positive operand wins, even against a "-000".
            greater_r <= ~lsa;
            less_r    <= lsa;
            state     <= S_DONE;
          end else begin
            state <= S_DIG2;
          end
        end
        S_DIG2, S_DIG1, S_DIG0: begin
          if (dig_a != dig_b) begin
            greater_r <= dig_gt ^ invert;
            less_r    <= ~(dig_gt ^ invert);
            state     <= S_DONE;
          end else if (state == S_DIG0) begin
            equal_r <= 1'b1;
            state   <= S_DONE;
          end else begin
            state <= state + 3'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.less      = less_r;
  assign bus.equal     = equal_r;
  assign bus.greater   = greater_r;
  assign bus.invalid   = invalid_r;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_bcd_cmp_seq.sv
// Self-checking bench for bcd_cmp_seq: directed vectors feed an expected
// queue; a negedge monitor pops and checks flags and done latency.
module tb_bcd_cmp_seq;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  // {less, equal, greater, invalid} , latency , sampling-edge index
  logic [27:0] exp_q[$];

  bcd_cmp_seq_if bus ();

  bcd_cmp_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running, expected finished");
    $fatal(1);
  end

  // ---------------- comparison helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [27:0] e;
    int          lat;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e   = exp_q.pop_front();
        lat = cyc - int'(e[15:0]) + 1;
        check("result_flags", {28'd0, bus.less, bus.equal, bus.greater, bus.invalid},
              {28'd0, e[27:24]});
        check("done_latency", lat, {24'd0, e[23:16]});
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; drives one request and returns at the first
  // negedge with busy low, so the next call starts in that IDLE cycle.
  task automatic run(input logic [11:0] a, input logic sa, input logic [11:0] b,
                     input logic sb, input logic [3:0] flags, input int lat,
                     input bit hold);
    int budget;
    bus.A      = a;
    bus.sign_a = sa;
    bus.B      = b;
    bus.sign_b = sb;
    bus.start  = 1'b1;
    exp_q.push_back({flags, 8'(lat), 16'(cyc + 1)});
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    // Operands must be ignored once latched.
    bus.A      = 12'($urandom_range(0, 4095));
    bus.B      = 12'($urandom_range(0, 4095));
    bus.sign_a = 1'($urandom_range(0, 1));
    bus.sign_b = 1'($urandom_range(0, 1));
    budget = 0;
    while (bus.busy && budget < 20) begin
      if (hold && bus.done) bus.start = 1'b0;
      @(negedge clk);
      budget++;
    end
    bus.start = 1'b0;
    if (budget >= 20) check("busy_timeout", 32'd1, 32'd0);
    check("flags_hold", {28'd0, bus.less, bus.equal, bus.greater, bus.invalid},
          {28'd0, flags});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;
    int seen;
    n_cmp      = 0;
    n_err      = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.A      = 12'h000;
    bus.B      = 12'h000;
    bus.sign_a = 1'b0;
    bus.sign_b = 1'b0;
    #1;
    check("reset_outputs", {23'd0, bus.busy, bus.done, bus.less, bus.equal, bus.greater,
          bus.invalid, bus.dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // flags = {less, equal, greater, invalid}
    run(12'h001, 1'b0, 12'h007, 1'b0, 4'b1000, 5, 1'b0);  // +001 vs +007
    run(12'h500, 1'b0, 12'h200, 1'b0, 4'b0010, 3, 1'b0);  // +500 vs +200
    run(12'h125, 1'b1, 12'h128, 1'b1, 4'b0010, 5, 1'b0);  // -125 vs -128
    run(12'h300, 1'b1, 12'h001, 1'b0, 4'b1000, 2, 1'b0);  // -300 vs +001
    run(12'h000, 1'b1, 12'h000, 1'b0, 4'b0100, 5, 1'b0);  // -000 vs +000
    run(12'h888, 1'b0, 12'h888, 1'b0, 4'b0100, 5, 1'b0);  // +888 vs +888
    run(12'h1A3, 1'b0, 12'h000, 1'b0, 4'b0001, 2, 1'b0);  // A digit invalid
    run(12'h100, 1'b0, 12'h0F0, 1'b0, 4'b0001, 2, 1'b0);  // B digit invalid
    run(12'h000, 1'b0, 12'h005, 1'b1, 4'b0010, 2, 1'b0);  // +000 vs -005
    run(12'h042, 1'b1, 12'h051, 1'b1, 4'b0010, 4, 1'b0);  // -042 vs -051
    run(12'h000, 1'b1, 12'h005, 1'b1, 4'b0010, 5, 1'b0);  // -000 vs -005
    run(12'h999, 1'b0, 12'h999, 1'b1, 4'b0010, 2, 1'b0);  // +999 vs -999
    run(12'h330, 1'b0, 12'h340, 1'b0, 4'b1000, 4, 1'b0);  // +330 vs +340

    // start held high through busy and DONE: exactly one compare
    run(12'h500, 1'b0, 12'h200, 1'b0, 4'b0010, 3, 1'b1);
    seen = 0;
    repeat (4) begin
      if (bus.busy) seen++;
      @(negedge clk);
    end
    check("held_start_no_retrigger", seen, 0);

    // abort in DIG1 with an asynchronous reset
    bus.A      = 12'h111;
    bus.sign_a = 1'b0;
    bus.B      = 12'h112;
    bus.sign_b = 1'b0;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    budget = 0;
    while (bus.dbg_state != 3'd3 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    check("reach_dig1", {29'd0, bus.dbg_state}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs", {23'd0, bus.busy, bus.done, bus.less, bus.equal, bus.greater,
          bus.invalid, bus.dbg_state}, 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    check("no_done_in_reset", seen, 0);
    rst = 1'b0;
    run(12'h123, 1'b0, 12'h122, 1'b0, 4'b0010, 5, 1'b0);  // accepted 1 edge after release

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
